next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  Fetch-stage PC generator for the pipelined CPU: holds the F-stage PC register, computes its successor
//  and applies D-stage branch/jump redirects, exception entry and ERET. A redirect raised while fetch is
//  stalled is buffered, not lost. Sits between IM address and the D-stage branch/jump comparator.
// PARAMETERS
//  PC_W       32            PC / target width (>= 30); J-region bits are [PC_W-1:28]
//  RESET_PC   32'h0000_3000 PC loaded on reset
//  EXC_VEC    32'h0000_4180 exception handler entry
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  stall        in   1      hold F-stage PC (hazard unit)
//  redir_valid  in   1      single-cycle pulse: D-stage instr resolved to a non-sequential target
//  redir_sel    in   2      0 SEQ, 1 BR, 2 JR, 3 J (J and JAL both use 3)
//  pc_d         in   PC_W   PC of the D-stage branch/jump
//  imm16        in   16     branch offset (words, signed)
//  imm26        in   26     jump index
//  reg_rs       in   PC_W   JR target register value
//  exc_req      in   1      enter exception this cycle
//  eret_req     in   1      return from exception this cycle
//  epc          in   PC_W   ERET target
//  pc_f         out  PC_W   current fetch PC
//  pc_valid     out  1      pc_f is a real fetch (0 = bubble)
//  redir_pend   out  1      a buffered redirect is waiting for stall release
//  pc_adel      out  1      fetch address misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert): pc_f=RESET_PC, pc_valid=0, redir_pend=0, pc_adel=0, state=BOOT.
//  Targets (mod 2^PC_W): BR = pc_d+4+(sext(imm16)<<2); JR = reg_rs; J = {pc_d[PC_W-1:28],imm26,2'b00};
//   SEQ with redir_valid=1 is ignored (treated as no redirect).
//  Sequential successor = pc_f+4, wraps silently at 2^PC_W. Delay slot = pc_d+4, fetched naturally.
//  FSM: BOOT -> RUN after first clock (pc_valid rises to 1, pc_f unchanged).
//   RUN: exc_req -> pc_f<=EXC_VEC; else eret_req -> pc_f<=epc; else redir_valid&!stall -> pc_f<=target;
//        else redir_valid&stall -> latch target, go PEND; else !stall -> pc_f<=pc_f+4; else hold.
//   PEND: redir_pend=1; pc_f held. First cycle with stall=0 -> pc_f<=latched target, go RUN.
//        New redir_valid in PEND overwrites latched target (with stall=0: new target applied same edge).
//  Priority every state: exc_req > eret_req > redirect > stall > sequential.
//  exc_req / eret_req ignore stall, clear any pending redirect, force RUN; exc+eret same cycle -> exc wins.
//  Reset mid-PEND discards the buffered target. Latency: all updates visible on pc_f one edge later.
// CONFIGURATION
//  NPC_ALIGN_CHECK_EN defined: pc_adel registered with pc_f = (pc_f_next[1:0]!=0) & pc_valid_next;
//   misaligned JR/ERET target is still loaded (exception unit reacts via pc_adel).
//  Not defined: pc_adel tied 0, no check logic.
// STRUCTURE
//  Package npc_pkg: redir_sel localparams (SEL_SEQ/BR/JR/J), FSM encodings (ST_BOOT/RUN/PEND),
//   default RESET_PC and EXC_VEC constants.
//  Sub-module npc_target_calc: purely combinational target mux (redir_sel, pc_d, imm16, imm26, reg_rs).
//  Top: FSM, pc_f register, pending-target register, align check.
// TESTING
//  Reset release, stall=0 for 3 clocks -> pc_f 3000,3000(valid=1),3004,3008.
//  pc_d=3010, BR, imm16=16'hFFFC, stall=0 -> next pc_f=3004.
//  J imm26=26'h0000C10, pc_d=3020, stall=1 for 2 clocks -> redir_pend=1, pc_f held; release -> pc_f=3040.
//  PEND with exc_req=1, stall=1 -> pc_f=4180, redir_pend=0; then eret_req, epc=3100 -> pc_f=3100.
//  pc_f=FFFF_FFFC, stall=0 -> pc_f=0000_0000 (wrap), no flag.
//  NPC_ALIGN_CHECK_EN: JR reg_rs=3002 -> pc_f=3002, pc_adel=1; without macro pc_adel=0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared constants for the fetch-stage next-PC unit: redirect selector codes,
// FSM state encoding and the default reset / exception-vector addresses.
package npc_pkg;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JR  = 2'd2;
  localparam logic [1:0] SEL_J   = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } npc_state_e;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NPC_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect-target mux for branch (PC-relative), register jump and
// region jump. tgt_valid is low for SEQ so a stray redirect pulse is ignored.
module npc_target_calc
  import npc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      redir_sel,
  input  logic [PC_W-1:0] pc_d,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [PC_W-1:0] reg_rs,
  output logic [PC_W-1:0] tgt,
  output logic            tgt_valid
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  logic signed [PC_W-1:0] br_off;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        j_tgt;

  // Word offset becomes a byte offset; sign extension keeps backward branches correct.
  assign br_off = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign br_tgt = pc_d + PC_INC + $unsigned(br_off);
  assign j_tgt  = {pc_d[PC_W-1:28], imm26, 2'b00};

  always_comb begin
    tgt       = pc_d + PC_INC;
    tgt_valid = 1'b0;
    unique case (redir_sel)
      SEL_BR: begin
        tgt       = br_tgt;
        tgt_valid = 1'b1;
      end
      SEL_JR: begin
        tgt       = reg_rs;
        tgt_valid = 1'b1;
      end
      SEL_J: begin
        tgt       = j_tgt;
        tgt_valid = 1'b1;
      end
      default: begin
        tgt       = pc_d + PC_INC;
        tgt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-stage PC generator: F-stage PC register, redirect buffering across stalls,
// exception entry / ERET. Optional misalignment flag under `NPC_ALIGN_CHECK_EN.
module next_pc_unit
  import npc_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(NPC_RESET_PC),
  parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(NPC_EXC_VEC)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [1:0]      redir_sel,
  input  logic [PC_W-1:0] pc_d,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [PC_W-1:0] reg_rs,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] pc_f,
  output logic            pc_valid,
  output logic            redir_pend,
  output logic            pc_adel
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  npc_state_e      state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [PC_W-1:0] tgt;
  logic            tgt_valid;
  logic            redir;

  npc_target_calc #(.PC_W(PC_W)) u_tgt (
    .redir_sel (redir_sel),
    .pc_d      (pc_d),
    .imm16     (imm16),
    .imm26     (imm26),
    .reg_rs    (reg_rs),
    .tgt       (tgt),
    .tgt_valid (tgt_valid)
  );

  assign redir = redir_valid & tgt_valid;

  // Priority: exception > ERET > redirect > stall > sequential, in every state.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_req) begin
      fpc_d   = EXC_VEC;
      state_d = ST_RUN;
    end else if (eret_req) begin
      fpc_d   = epc;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (redir && !stall) begin
            fpc_d = tgt;
          end else if (redir) begin
            pend_tgt_d = tgt;
            state_d    = ST_PEND;
          end else if (!stall) begin
            fpc_d = fpc_q + PC_INC;
          end
        end
        ST_PEND: begin
          if (redir && !stall) begin
            fpc_d   = tgt;
            state_d = ST_RUN;
          end else if (redir) begin
            pend_tgt_d = tgt;
          end else if (!stall) begin
            fpc_d   = pend_tgt_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
    end
  end

  // Only meaningful while in PEND; the state reset discards any stale value.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign pc_f       = fpc_q;
  assign pc_valid   = (state_q != ST_BOOT);
  assign redir_pend = (state_q == ST_PEND);

`ifdef NPC_ALIGN_CHECK_EN
  logic adel_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adel_q <= 1'b0;
    end else begin
      adel_q <= (fpc_d[1:0] != 2'b00) & (state_d != ST_BOOT);
    end
  end

  assign pc_adel = adel_q;
`else
  assign pc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table driven through a scoreboard
// queue, plus a hand-written reset-during-pending sequence.
module tb_next_pc_unit;
  import npc_pkg::*;

`ifdef NPC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redir_valid, exc_req, eret_req;
  logic [1:0]  redir_sel;
  logic [31:0] pc_d, reg_rs, epc, pc_f;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        pc_valid, redir_pend, pc_adel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redir_valid(redir_valid),
    .redir_sel(redir_sel), .pc_d(pc_d), .imm16(imm16), .imm26(imm26),
    .reg_rs(reg_rs), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc_f(pc_f), .pc_valid(pc_valid), .redir_pend(redir_pend), .pc_adel(pc_adel)
  );

  typedef struct {
    logic        stall, rv;
    logic [1:0]  sel;
    logic [31:0] pcd;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
    logic        exc, eret;
    logic [31:0] epc;
    logic [31:0] xpc;
    logic        xvalid, xpend;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid, pend, adel;
    int          id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mkv(logic st, logic rv, logic [1:0] sel, logic [31:0] pcd,
                               logic [15:0] i16, logic [25:0] i26, logic [31:0] rs,
                               logic exc, logic eret, logic [31:0] ep,
                               logic [31:0] xpc, logic xvalid, logic xpend);
    vec_t v;
    v.stall = st; v.rv = rv; v.sel = sel; v.pcd = pcd; v.i16 = i16; v.i26 = i26;
    v.rs = rs; v.exc = exc; v.eret = eret; v.epc = ep;
    v.xpc = xpc; v.xvalid = xvalid; v.xpend = xpend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    stall = 1'b0; redir_valid = 1'b0; redir_sel = SEL_SEQ; pc_d = '0;
    imm16 = '0; imm26 = '0; reg_rs = '0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;
  endtask

  // Called at a falling edge; drives one vector, checks the result after the next rising edge.
  task automatic drive(input vec_t v, input int id);
    exp_t e, got;
    stall = v.stall; redir_valid = v.rv; redir_sel = v.sel; pc_d = v.pcd;
    imm16 = v.i16; imm26 = v.i26; reg_rs = v.rs; exc_req = v.exc;
    eret_req = v.eret; epc = v.epc;
    e.pc = v.xpc; e.valid = v.xvalid; e.pend = v.xpend; e.id = id;
    e.adel = ALIGN_EN && v.xvalid && (v.xpc[1:0] != 2'b00);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL v%0d.scoreboard actual=empty expected=entry", id);
    end else begin
      got = sb.pop_front();
      check($sformatf("v%0d.pc_f", got.id), pc_f, got.pc);
      check($sformatf("v%0d.pc_valid", got.id), {31'd0, pc_valid}, {31'd0, got.valid});
      check($sformatf("v%0d.redir_pend", got.id), {31'd0, redir_pend}, {31'd0, got.pend});
      check($sformatf("v%0d.pc_adel", got.id), {31'd0, pc_adel}, {31'd0, got.adel});
    end
    @(negedge clk);
  endtask

  initial begin
    // stall rv sel pcd i16 i26 rs exc eret epc | exp pc valid pend
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3000,1,0));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3004,1,0));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3008,1,0));
    tbl.push_back(mkv(1,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3008,1,0));
    tbl.push_back(mkv(0,1,SEL_BR,32'h3010,16'hFFFC,0,0,0,0,0, 32'h3004,1,0));
    tbl.push_back(mkv(1,1,SEL_J,32'h3020,0,26'h0000C10,0,0,0,0, 32'h3004,1,1));
    tbl.push_back(mkv(1,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3004,1,1));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3040,1,0));
    tbl.push_back(mkv(1,1,SEL_J,32'h3020,0,26'h0000C10,0,0,0,0, 32'h3040,1,1));
    tbl.push_back(mkv(1,0,SEL_SEQ,0,0,0,0,1,0,0, 32'h4180,1,0));
    tbl.push_back(mkv(1,0,SEL_SEQ,0,0,0,0,0,1,32'h3100, 32'h3100,1,0));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,1,1,32'h3100, 32'h4180,1,0));
    tbl.push_back(mkv(0,1,SEL_JR,0,0,0,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC,1,0));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h0000_0000,1,0));
    tbl.push_back(mkv(1,1,SEL_BR,32'h100,16'h0004,0,0,0,0,0, 32'h0,1,1));
    tbl.push_back(mkv(1,1,SEL_J,32'h0,0,26'h40,0,0,0,0, 32'h0,1,1));
    tbl.push_back(mkv(0,1,SEL_JR,0,0,0,32'h200,0,0,0, 32'h200,1,0));
    tbl.push_back(mkv(0,1,SEL_SEQ,32'h500,0,0,32'h700,0,0,0, 32'h204,1,0));
    tbl.push_back(mkv(0,1,SEL_JR,0,0,0,32'h3002,0,0,0, 32'h3002,1,0));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3006,1,0));
    tbl.push_back(mkv(0,1,SEL_JR,0,0,0,32'h3000,0,0,0, 32'h3000,1,0));
    // Buffered BR target applied on release after stall.
    tbl.push_back(mkv(1,1,SEL_BR,32'h3000,16'h0010,0,0,0,0,0, 32'h3000,1,1));
    tbl.push_back(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3044,1,0));

    set_idle();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst.pc_f", pc_f, 32'h3000);
    check("rst.pc_valid", {31'd0, pc_valid}, 32'd0);
    check("rst.redir_pend", {31'd0, redir_pend}, 32'd0);
    check("rst.pc_adel", {31'd0, pc_adel}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], i);

    // Reset asserted while a redirect is buffered must drop the buffered target.
    drive(mkv(1,1,SEL_J,32'h3020,0,26'h0000C10,0,0,0,0, 32'h3044,1,1), 100);
    reset_n = 1'b0;
    #1;
    check("midrst.pc_f", pc_f, 32'h3000);
    check("midrst.pc_valid", {31'd0, pc_valid}, 32'd0);
    check("midrst.redir_pend", {31'd0, redir_pend}, 32'd0);
    set_idle();
    @(negedge clk);
    reset_n = 1'b1;
    drive(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3000,1,0), 101);
    drive(mkv(0,0,SEL_SEQ,0,0,0,0,0,0,0, 32'h3004,1,0), 102);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard.drain actual=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
